// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - scan codes, direction encodings and receiver state type for the PS/2 front end
package ps2_pkg;

    localparam logic [7:0] SC_BREAK     = 8'hF0;
    localparam logic [7:0] SC_EXT       = 8'hE0;
    localparam logic [7:0] SC_UP        = 8'h1D;
    localparam logic [7:0] SC_LEFT      = 8'h1C;
    localparam logic [7:0] SC_DOWN      = 8'h1B;
    localparam logic [7:0] SC_RIGHT     = 8'h23;
    localparam logic [7:0] SC_ENTER     = 8'h5A;
    localparam logic [7:0] SC_SPACE     = 8'h29;
    localparam logic [7:0] SC_ARR_UP    = 8'h75;
    localparam logic [7:0] SC_ARR_LEFT  = 8'h6B;
    localparam logic [7:0] SC_ARR_DOWN  = 8'h72;
    localparam logic [7:0] SC_ARR_RIGHT = 8'h74;

    // Bit order is {right, down, left, up}; opposites sit two bits apart.
    localparam logic [3:0] DIR_NONE  = 4'b0000;
    localparam logic [3:0] DIR_UP    = 4'b0001;
    localparam logic [3:0] DIR_LEFT  = 4'b0010;
    localparam logic [3:0] DIR_DOWN  = 4'b0100;
    localparam logic [3:0] DIR_RIGHT = 4'b1000;

    typedef logic [1:0] rx_state_t;
    localparam rx_state_t ST_IDLE  = 2'd0;
    localparam rx_state_t ST_RECV  = 2'd1;
    localparam rx_state_t ST_CHECK = 2'd2;

    function automatic logic [3:0] dir_opposite(input logic [3:0] d);
        return {d[1:0], d[3:2]};
    endfunction

    function automatic logic odd_parity_ok(input logic [8:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/ps2_direction_decoder_if.sv
// rtl/ps2_direction_decoder_if.sv - raw PS/2 lines and decoded game controls
interface ps2_direction_decoder_if;

    logic       KB_clk;
    logic       data;
    logic       up;
    logic       left;
    logic       down;
    logic       right;
    logic       start;
    logic       shoot;
    logic [7:0] scan_code;
    logic       code_valid;
    logic       frame_error;

    modport master (
        output KB_clk, data,
        input  up, left, down, right, start, shoot, scan_code, code_valid, frame_error
    );

    modport slave (
        input  KB_clk, data,
        output up, left, down, right, start, shoot, scan_code, code_valid, frame_error
    );

endinterface

// File: rtl/ps2_frame_rx.sv
// rtl/ps2_frame_rx.sv - PS/2 frame receiver: synchronizers, falling-edge detect, framing, parity and timeout
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       master_clk,
    input  logic       reset_n,
    input  logic       KB_clk,
    input  logic       data,
    output logic [7:0] scan_code,
    output logic       code_valid,
    output logic       frame_error
);

    localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic          kb_s1, kb_s2, kb_prev;
    logic          d_s1, d_s2;
    logic          kb_fall;
    rx_state_t     state;
    logic [3:0]    bit_cnt;
    logic [9:0]    shift_reg;
    logic [TW-1:0] tmo_cnt;

    // PS/2 idles high, so the clock synchronizer resets high to avoid a phantom edge.
    always_ff @(posedge master_clk or negedge reset_n) begin
        if (!reset_n) begin
            kb_s1   <= 1'b1;
            kb_s2   <= 1'b1;
            kb_prev <= 1'b1;
            d_s1    <= 1'b1;
            d_s2    <= 1'b1;
        end else begin
            kb_s1   <= KB_clk;
            kb_s2   <= kb_s1;
            kb_prev <= kb_s2;
            d_s1    <= data;
            d_s2    <= d_s1;
        end
    end

    assign kb_fall = kb_prev & ~kb_s2;

    always_ff @(posedge master_clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            bit_cnt     <= 4'd0;
            shift_reg   <= 10'd0;
            tmo_cnt     <= '0;
            scan_code   <= 8'd0;
            code_valid  <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            code_valid  <= 1'b0;
            frame_error <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (kb_fall && !d_s2) begin
                        state   <= ST_RECV;
                        bit_cnt <= 4'd1;
                        tmo_cnt <= '0;
                    end
                end
                ST_RECV: begin
                    // An edge in the same cycle as the timeout keeps the frame alive.
                    if (kb_fall) begin
                        shift_reg <= {d_s2, shift_reg[9:1]};
                        bit_cnt   <= bit_cnt + 4'd1;
                        tmo_cnt   <= '0;
                        if (bit_cnt == 4'd10) begin
                            state <= ST_CHECK;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        state       <= ST_IDLE;
                        frame_error <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                ST_CHECK: begin
                    state <= ST_IDLE;
                    if (odd_parity_ok(shift_reg[8:0]) && shift_reg[9]) begin
                        code_valid <= 1'b1;
                        scan_code  <= shift_reg[7:0];
                    end else begin
                        frame_error <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ps2_direction_decoder.sv
// rtl/ps2_direction_decoder.sv - PS/2 key decode to direction/start/shoot; PS2_EXT_ARROWS_EN adds E0 arrow keys
module ps2_direction_decoder
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int REJECT_REVERSE = 1
) (
    input  logic                    master_clk,
    input  logic                    reset_n,
    ps2_direction_decoder_if.slave  bus
);

    logic [7:0] scan_code;
    logic       code_valid;
    logic       frame_error;

    ps2_frame_rx #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .master_clk  (master_clk),
        .reset_n     (reset_n),
        .KB_clk      (bus.KB_clk),
        .data        (bus.data),
        .scan_code   (scan_code),
        .code_valid  (code_valid),
        .frame_error (frame_error)
    );

    logic       brk;
    logic [3:0] dir;
    logic       start_q;
    logic       shoot_q;
    logic [3:0] base_dir;
    logic       base_start;
    logic       base_fire;
    logic [3:0] key_dir;
    logic       key_start;
    logic       key_fire;
    logic       accept_dir;

    always_comb begin
        base_dir   = DIR_NONE;
        base_start = 1'b0;
        base_fire  = 1'b0;
        case (scan_code)
            SC_UP:    base_dir   = DIR_UP;
            SC_LEFT:  base_dir   = DIR_LEFT;
            SC_DOWN:  base_dir   = DIR_DOWN;
            SC_RIGHT: base_dir   = DIR_RIGHT;
            SC_ENTER: base_start = 1'b1;
            SC_SPACE: base_fire  = 1'b1;
            default:  ;
        endcase
    end

`ifdef PS2_EXT_ARROWS_EN
    logic       ext;
    logic [3:0] arrow_dir;

    always_comb begin
        arrow_dir = DIR_NONE;
        case (scan_code)
            SC_ARR_UP:    arrow_dir = DIR_UP;
            SC_ARR_LEFT:  arrow_dir = DIR_LEFT;
            SC_ARR_DOWN:  arrow_dir = DIR_DOWN;
            SC_ARR_RIGHT: arrow_dir = DIR_RIGHT;
            default:      ;
        endcase
    end

    // Extended keys only ever steer; every other E0-prefixed key is dropped.
    assign key_dir   = ext ? arrow_dir : base_dir;
    assign key_start = base_start & ~ext;
    assign key_fire  = base_fire & ~ext;
`else
    assign key_dir   = base_dir;
    assign key_start = base_start;
    assign key_fire  = base_fire;
`endif

    assign accept_dir = (key_dir != DIR_NONE) &&
                        !((REJECT_REVERSE != 0) && (dir != DIR_NONE) &&
                          (key_dir == dir_opposite(dir)));

    always_ff @(posedge master_clk or negedge reset_n) begin
        if (!reset_n) begin
            brk     <= 1'b0;
            dir     <= DIR_NONE;
            start_q <= 1'b0;
            shoot_q <= 1'b0;
`ifdef PS2_EXT_ARROWS_EN
            ext     <= 1'b0;
`endif
        end else begin
            shoot_q <= 1'b0;
            if (code_valid) begin
                if (scan_code == SC_BREAK) begin
                    brk <= 1'b1;
                end else if (scan_code == SC_EXT) begin
`ifdef PS2_EXT_ARROWS_EN
                    ext <= 1'b1;
`endif
                end else begin
                    brk <= 1'b0;
`ifdef PS2_EXT_ARROWS_EN
                    ext <= 1'b0;
`endif
                    if (!brk) begin
                        if (accept_dir) begin
                            dir <= key_dir;
                        end
                        if (key_start) begin
                            start_q <= ~start_q;
                        end
                        if (key_fire) begin
                            shoot_q <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign bus.up          = dir[0];
    assign bus.left        = dir[1];
    assign bus.down        = dir[2];
    assign bus.right       = dir[3];
    assign bus.start       = start_q;
    assign bus.shoot       = shoot_q;
    assign bus.scan_code   = scan_code;
    assign bus.code_valid  = code_valid;
    assign bus.frame_error = frame_error;

endmodule

// File: tb/tb_ps2_direction_decoder.sv
// tb/tb_ps2_direction_decoder.sv - randomized self-checking bench for ps2_direction_decoder
module tb_ps2_direction_decoder;

    localparam int TMO = 64;
    localparam int H   = 4;
`ifdef PS2_EXT_ARROWS_EN
    localparam bit EXT_EN = 1'b1;
`else
    localparam bit EXT_EN = 1'b0;
`endif

    logic master_clk = 1'b0;
    logic reset_n    = 1'b0;
    int   checks     = 0;
    int   errors     = 0;
    int   cyc        = 0;
    int   stop_cyc   = 0;

    ps2_direction_decoder_if bus ();

    ps2_direction_decoder #(
        .TIMEOUT_CYCLES (TMO),
        .REJECT_REVERSE (1)
    ) dut (
        .master_clk (master_clk),
        .reset_n    (reset_n),
        .bus        (bus)
    );

    always #10 master_clk = ~master_clk;
    always @(posedge master_clk) cyc <= cyc + 1;

    // Reference model: direction as 0=none,1=up,2=left,3=down,4=right.
    int         m_dir;
    bit         m_start, m_brk, m_ext, m_shoot;
    logic [7:0] m_scan;

    function automatic void model_reset();
        m_dir = 0; m_start = 0; m_brk = 0; m_ext = 0; m_shoot = 0; m_scan = 8'h00;
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        int req;
        req     = 0;
        m_shoot = 0;
        m_scan  = b;
        if (b == 8'hF0) begin
            m_brk = 1;
        end else if (b == 8'hE0) begin
            if (EXT_EN) m_ext = 1;
        end else begin
            if (!m_brk) begin
                if (m_ext) begin
                    case (b)
                        8'h75: req = 1;
                        8'h6B: req = 2;
                        8'h72: req = 3;
                        8'h74: req = 4;
                        default: req = 0;
                    endcase
                end else begin
                    case (b)
                        8'h1D: req = 1;
                        8'h1C: req = 2;
                        8'h1B: req = 3;
                        8'h23: req = 4;
                        8'h5A: m_start = !m_start;
                        8'h29: m_shoot = 1;
                        default: req = 0;
                    endcase
                end
                if (req != 0 && !(m_dir != 0 && req == (m_dir + 1) % 4 + 1)) m_dir = req;
            end
            m_brk = 0;
            m_ext = 0;
        end
    endfunction

    function automatic logic [3:0] m_bits();
        case (m_dir)
            1: return 4'b1000;
            2: return 4'b0100;
            3: return 4'b0010;
            4: return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    int         o_valid, o_err, o_shoot, o_lat;
    logic [3:0] o_dir;
    logic       o_start;
    logic [7:0] o_scan;

    function automatic logic [10:0] mk(input logic [7:0] b, input bit badp);
        return {1'b1, (~^b) ^ badp, b, 1'b0};
    endfunction

    function automatic logic [22:0] pack_got();
        return {4'(o_valid), 4'(o_err), o_scan, o_dir, o_start, 2'(o_shoot)};
    endfunction

    function automatic logic [22:0] pack_exp(input int v, input int e);
        return {4'(v), 4'(e), m_scan, m_bits(), m_start, 2'(m_shoot)};
    endfunction

    task automatic drive_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            bus.data = bits[i];
            repeat (H) @(negedge master_clk);
            bus.KB_clk = 1'b0;
            stop_cyc   = cyc;
            repeat (H) @(negedge master_clk);
            bus.KB_clk = 1'b1;
        end
    endtask

    task automatic observe(input int len);
        bit seen;
        seen = 0; o_valid = 0; o_err = 0; o_shoot = 0; o_lat = -1;
        for (int i = 0; i < len; i++) begin
            @(negedge master_clk);
            if (seen) begin
                o_dir   = {bus.up, bus.left, bus.down, bus.right};
                o_start = bus.start;
                seen    = 0;
            end
            if (bus.code_valid === 1'b1) begin
                o_valid++;
                o_lat = cyc - stop_cyc;
                seen  = 1;
            end
            if (bus.frame_error === 1'b1) o_err++;
            if (bus.shoot === 1'b1) o_shoot++;
        end
        if (o_valid == 0) begin
            o_dir   = {bus.up, bus.left, bus.down, bus.right};
            o_start = bus.start;
        end
        o_scan = bus.scan_code;
    endtask

    task automatic xfer(input logic [10:0] bits, input int n, input int len);
        fork
            drive_bits(bits, n);
            observe(len);
        join
    endtask

    task automatic send_frame(input logic [7:0] b, input bit badp);
        m_shoot = 0;
        xfer(mk(b, badp), 11, 22 * H + 24);
        if (!badp) model_byte(b);
    endtask

    task automatic test_reset();
        bus.KB_clk = 1'b1;
        bus.data   = 1'b1;
        reset_n    = 1'b0;
        model_reset();
        repeat (3) @(negedge master_clk);
        checks++;
        if ({bus.up, bus.left, bus.down, bus.right, bus.start, bus.shoot, bus.scan_code,
             bus.code_valid, bus.frame_error} !== 16'h0000)
            begin errors++; $display("FAIL reset_outputs got=%b%b%b%b%b%b %h %b%b required all zero",
                bus.up, bus.left, bus.down, bus.right, bus.start, bus.shoot, bus.scan_code,
                bus.code_valid, bus.frame_error); end
        reset_n = 1'b1;
        repeat (3) @(negedge master_clk);
    endtask

    task automatic test_directions();
        logic [7:0] seq [3];
        seq = '{8'h1D, 8'h1B, 8'h1C};
        foreach (seq[i]) begin
            send_frame(seq[i], 0);
            checks++;
            if (pack_got() !== pack_exp(1, 0))
                begin errors++; $display("FAIL dir_%h got=%h required=%h", seq[i], pack_got(), pack_exp(1, 0)); end
            checks++;
            if (o_lat !== 4)
                begin errors++; $display("FAIL latency_%h got=%0d required=4", seq[i], o_lat); end
        end
    endtask

    task automatic test_parity_error();
        send_frame(8'h23, 1);
        checks++;
        if (pack_got() !== pack_exp(0, 1))
            begin errors++; $display("FAIL parity_error got=%h required=%h", pack_got(), pack_exp(0, 1)); end
    endtask

    task automatic test_timeout();
        send_frame(8'h1D, 0);
        checks++;
        if (pack_got() !== pack_exp(1, 0))
            begin errors++; $display("FAIL pre_timeout got=%h required=%h", pack_got(), pack_exp(1, 0)); end
        xfer(mk(8'h55, 0), 5, 10 * H + TMO + 30);
        checks++;
        if (o_err !== 1 || o_valid !== 0)
            begin errors++; $display("FAIL timeout got err=%0d valid=%0d required err=1 valid=0", o_err, o_valid); end
        send_frame(8'h23, 0);
        checks++;
        if (pack_got() !== pack_exp(1, 0))
            begin errors++; $display("FAIL post_timeout got=%h required=%h", pack_got(), pack_exp(1, 0)); end
    endtask

    task automatic test_prefix();
        logic [7:0] seq [6];
        seq = '{8'hF0, 8'h1D, 8'h5A, 8'hF0, 8'h5A, 8'h29};
        foreach (seq[i]) begin
            send_frame(seq[i], 0);
            checks++;
            if (pack_got() !== pack_exp(1, 0))
                begin errors++; $display("FAIL prefix_%0d_%h got=%h required=%h", i, seq[i], pack_got(), pack_exp(1, 0)); end
        end
    endtask

    task automatic test_reset_midframe();
        drive_bits(mk(8'h1D, 0), 5);
        @(negedge master_clk);
        reset_n = 1'b0;
        model_reset();
        @(negedge master_clk);
        checks++;
        if ({bus.up, bus.left, bus.down, bus.right, bus.start, bus.shoot, bus.scan_code,
             bus.code_valid, bus.frame_error} !== 16'h0000)
            begin errors++; $display("FAIL midframe_reset got=%b%b%b%b %b %h required all zero",
                bus.up, bus.left, bus.down, bus.right, bus.start, bus.scan_code); end
        reset_n = 1'b1;
        repeat (3) @(negedge master_clk);
        send_frame(8'h1D, 0);
        checks++;
        if (pack_got() !== pack_exp(1, 0))
            begin errors++; $display("FAIL after_reset_1d got=%h required=%h", pack_got(), pack_exp(1, 0)); end
    endtask

    task automatic test_ext();
        logic [7:0] seq [4];
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(negedge master_clk);
        reset_n = 1'b1;
        seq = '{8'hE0, 8'h75, 8'hE0, 8'h5A};
        foreach (seq[i]) begin
            send_frame(seq[i], 0);
            checks++;
            if (pack_got() !== pack_exp(1, 0))
                begin errors++; $display("FAIL ext_%0d_%h got=%h required=%h", i, seq[i], pack_got(), pack_exp(1, 0)); end
            if (i == 1) begin
                checks++;
                if (bus.up !== EXT_EN)
                    begin errors++; $display("FAIL ext_arrow_up got=%b required=%b", bus.up, EXT_EN); end
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] pool [12];
        logic [7:0] b;
        bit         badp;
        pool = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h5A, 8'h29, 8'hF0, 8'hE0, 8'h75, 8'h6B, 8'h72, 8'h74};
        for (int n = 0; n < 40; n++) begin
            b    = ($urandom_range(0, 4) == 0) ? 8'($urandom) : pool[$urandom_range(0, 11)];
            badp = ($urandom_range(0, 7) == 0);
            send_frame(b, badp);
            checks++;
            if (pack_got() !== pack_exp(badp ? 0 : 1, badp ? 1 : 0))
                begin errors++; $display("FAIL random_%0d_%h_bad%0d got=%h required=%h",
                    n, b, badp, pack_got(), pack_exp(badp ? 0 : 1, badp ? 1 : 0)); end
        end
    endtask

    initial begin
        test_reset();
        test_directions();
        test_parity_error();
        test_timeout();
        test_prefix();
        test_reset_midframe();
        test_ext();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
